// File: rtl/t10_lcd_pkg.sv
// Shared types and geometry for the 16x2 LCD text buffer.
package t10_lcd_pkg;

    localparam int LCD_COLS  = 16;
    localparam int LCD_ROWS  = 2;
    localparam int LCD_CHARS = 32;
    localparam int CHAR_W    = 8;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'b00,
        OP_SETPOS = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_COMMIT = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_CLEAR  = 2'b01,
        ST_COMMIT = 2'b10
    } state_e;

endpackage

// File: rtl/lcd_text_buffer.sv
// Character-level shadow buffer feeding a 16x2 LCD controller.
// Commands (WRITE / SETPOS / CLEAR / COMMIT) arrive over a valid/ready port
// and edit a 32-byte shadow; COMMIT copies the whole shadow to row_1/row_2
// in one edge and pulses strobe, so the display never sees a partial frame.
//
// Handshake: a command transfers on a posedge where cmd_valid && cmd_ready.
// cmd_ready depends only on the FSM state (high in IDLE), never on cmd_valid;
// the source must hold cmd_valid/cmd_op/cmd_data stable until the transfer.
//
// Optional build macro LCD_TEXT_AUTO_COMMIT_EN: when defined, the end of a
// CLEAR and a stored WRITE at position 31 both perform a commit themselves.
module lcd_text_buffer
    import t10_lcd_pkg::*;
#(
    parameter logic [7:0] FILL_CHAR    = 8'h20,
    parameter logic [7:0] NEWLINE_CHAR = 8'h0A
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [7:0]   cmd_data,
    output logic [4:0]   cursor,
    output logic         busy,
    output logic [127:0] row_1,
    output logic [127:0] row_2,
    output logic         strobe
);

    state_e            state_q, state_d;
    logic [4:0]        cursor_q, cursor_d;
    logic [4:0]        idx_q, idx_d;
    logic [CHAR_W-1:0] shadow_q [LCD_CHARS];
    logic [CHAR_W-1:0] shadow_d [LCD_CHARS];
    logic [127:0]      row_1_q, row_1_d;
    logic [127:0]      row_2_q, row_2_d;
    logic              strobe_q, strobe_d;
    logic              do_commit;
    op_e               op;

    assign op = op_e'(cmd_op);

    // Next-state, cursor and shadow edits; commit decision feeds the row copy.
    always_comb begin
        state_d   = state_q;
        cursor_d  = cursor_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        strobe_d  = 1'b0;
        do_commit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (op)
                        OP_WRITE: begin
                            if (cmd_data == NEWLINE_CHAR) begin
                                // Line break: jump to column 0 of the other row.
                                cursor_d = {~cursor_q[4], 4'h0};
                            end else begin
                                shadow_d[cursor_q] = cmd_data;
                                cursor_d           = cursor_q + 5'd1;
`ifdef LCD_TEXT_AUTO_COMMIT_EN
                                if (cursor_q == 5'd31) begin
                                    do_commit = 1'b1;
                                end
`endif
                            end
                        end
                        OP_SETPOS: cursor_d = cmd_data[4:0];
                        OP_CLEAR: begin
                            idx_d   = 5'd0;
                            state_d = ST_CLEAR;
                        end
                        OP_COMMIT: do_commit = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_CLEAR: begin
                shadow_d[idx_q] = FILL_CHAR;
                idx_d           = idx_q + 5'd1;
                if (idx_q == 5'd31) begin
                    cursor_d = 5'd0;
`ifdef LCD_TEXT_AUTO_COMMIT_EN
                    do_commit = 1'b1;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (do_commit) begin
            state_d  = ST_COMMIT;
            strobe_d = 1'b1;
        end
    end

    // Row copy packs from the post-edit shadow so a same-edge write is included.
    always_comb begin
        row_1_d = row_1_q;
        row_2_d = row_2_q;
        if (do_commit) begin
            for (int c = 0; c < LCD_COLS; c++) begin
                row_1_d[127-8*c -: 8] = shadow_d[c];
                row_2_d[127-8*c -: 8] = shadow_d[LCD_COLS+c];
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cursor_q <= 5'd0;
            idx_q    <= 5'd0;
            for (int i = 0; i < LCD_CHARS; i++) begin
                shadow_q[i] <= FILL_CHAR;
            end
            row_1_q  <= {LCD_COLS{FILL_CHAR}};
            row_2_q  <= {LCD_COLS{FILL_CHAR}};
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            row_1_q  <= row_1_d;
            row_2_q  <= row_2_d;
            strobe_q <= strobe_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign cursor    = cursor_q;
    assign row_1     = row_1_q;
    assign row_2     = row_2_q;
    assign strobe    = strobe_q;

endmodule
